// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared types and widths for the 64-bit pipelined core front end.
//   INSTR_W     : instruction word width
//   ADDR_W      : PC / address width
//   fetch_pkt_t : {pc, instr} pair produced by fetch/imem
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// ----------------------------------------------------------------------------
// if_id_buffer_if
// Fetch-side and decode-side handshake bundle of the IF/ID instruction queue.
//   fetch : imem_addr_F, imem_data_F, valid_F (to queue), ready_F (from queue),
//           Flush_F (redirect, to queue)
//   decode: pc_D, instr_D, valid_D (from queue), ready_D (to queue)
//   status: stall_cnt (from queue)
// Modports:
//   slave  : the queue itself
//   master : the surrounding pipeline (fetch + decode)
// ----------------------------------------------------------------------------
interface if_id_buffer_if
    import core_pkg::*;
#(
    parameter int N = ADDR_W,
    parameter int W = INSTR_W
);

    logic [N-1:0]  imem_addr_F;
    logic [W-1:0]  imem_data_F;
    logic          valid_F;
    logic          ready_F;
    logic          Flush_F;
    logic [N-1:0]  pc_D;
    logic [W-1:0]  instr_D;
    logic          valid_D;
    logic          ready_D;
    logic [31:0]   stall_cnt;

    modport slave (
        input  imem_addr_F, imem_data_F, valid_F, Flush_F, ready_D,
        output ready_F, pc_D, instr_D, valid_D, stall_cnt
    );

    modport master (
        output imem_addr_F, imem_data_F, valid_F, Flush_F, ready_D,
        input  ready_F, pc_D, instr_D, valid_D, stall_cnt
    );

endinterface

// File: rtl/if_id_buffer_ifq_mem.sv
// ----------------------------------------------------------------------------
// ifq_mem
// Storage array of the IF/ID queue: DEPTH x DW registers, one synchronous
// write port and one asynchronous read port. Contents are never reset; the
// queue only ever reads slots it has written since the last reset/flush.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module ifq_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Instruction queue between fetch and decode. Holds up to DEPTH {PC, instr}
// pairs, presents the oldest to decode, back-pressures fetch when full and
// empties on a taken branch (Flush_F).
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : if_id_buffer_if.slave (fetch offer, decode head, stall_cnt)
// ready_F / valid_D come from the registered count only, so there is no
// combinational path from valid_F or ready_D to the handshake outputs.
// stall_cnt counts cycles in which fetch offered while the queue was full,
// saturating at all-ones.
// ----------------------------------------------------------------------------
module if_id_buffer
    import core_pkg::*;
#(
    parameter int N     = ADDR_W,
    parameter int W     = INSTR_W,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    if_id_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    stall_cnt_q, stall_cnt_d;
    logic           ready_f;
    logic           valid_d;
    logic           push;
    logic           pop;
    logic [N+W-1:0] head_entry;

    assign ready_f = (count_q != FULL_CNT);
    assign valid_d = (count_q != '0);
    assign push    = bus.valid_F & ready_f & ~bus.Flush_F;
    assign pop     = valid_d & bus.ready_D;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;

        // A pop during a flush is still a completed handshake for decode,
        // but the flush wipes the queue state regardless.
        if (bus.Flush_F) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (bus.valid_F && !ready_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    ifq_mem #(
        .DEPTH (DEPTH),
        .DW    (N + W)
    ) u_ifq_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({bus.imem_addr_F, bus.imem_data_F}),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Stale storage is never exposed: head is zero whenever the queue is empty.
    assign bus.pc_D      = valid_d ? head_entry[N+W-1:W] : '0;
    assign bus.instr_D   = valid_d ? head_entry[W-1:0]   : '0;
    assign bus.valid_D   = valid_d;
    assign bus.ready_F   = ready_f;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
    import core_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_buffer_if #(.N(ADDR_W), .W(INSTR_W)) bus ();

    if_id_buffer #(.N(ADDR_W), .W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: FIFO of packets plus a saturating stall counter
    fetch_pkt_t  mq[$];
    logic [31:0] m_stall;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] e_pc;
        logic [31:0] e_in;
        e_pc = '0;
        e_in = '0;
        if (mq.size() != 0) begin
            e_pc = mq[0].pc;
            e_in = mq[0].instr;
        end
        chk({tag, ".valid_D"}, 64'(bus.valid_D), 64'(mq.size() != 0));
        chk({tag, ".ready_F"}, 64'(bus.ready_F), 64'(mq.size() != DEPTH));
        chk({tag, ".pc_D"}, bus.pc_D, e_pc);
        chk({tag, ".instr_D"}, 64'(bus.instr_D), 64'(e_in));
        chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall));
    endtask

    // One clock cycle: drive inputs (called just after a falling edge),
    // advance the model at the rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic vf, input logic [63:0] pc,
                        input logic [31:0] ins, input logic fl, input logic rd);
        logic full;
        logic do_pop;
        logic do_push;
        fetch_pkt_t p;
        bus.valid_F     = vf;
        bus.imem_addr_F = pc;
        bus.imem_data_F = ins;
        bus.Flush_F     = fl;
        bus.ready_D     = rd;
        @(posedge clk);
        full    = (mq.size() == DEPTH);
        do_pop  = (mq.size() != 0) && rd;
        do_push = vf && !full;
        if (vf && full && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                p.pc    = pc;
                p.instr = ins;
                mq.push_back(p);
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [31:0] ins_of(input logic [63:0] pc);
        return pc[31:0] + 32'hD000_0000;
    endfunction

    logic [63:0] heads[5];
    logic [63:0] exp_heads[5];

    initial begin
        bus.valid_F     = 1'b0;
        bus.imem_addr_F = '0;
        bus.imem_data_F = '0;
        bus.Flush_F     = 1'b0;
        bus.ready_D     = 1'b0;
        m_stall         = '0;
        reset           = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_outputs("post_reset");

        // fill to full, then hold a fifth offer against back-pressure
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 64'(i * 4), ins_of(64'(i * 4)), 1'b0, 1'b0);
        chk("fill.full", 64'(bus.ready_F), 64'd0);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 64'h10, ins_of(64'h10), 1'b0, 1'b0);
        chk("hold.stall3", 64'(bus.stall_cnt), 64'd3);
        exp_heads = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        for (int i = 0; i < 5; i++) begin
            heads[i] = bus.pc_D;
            step("drain", (i < 2), 64'h10, ins_of(64'h10), 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) chk($sformatf("drain.order%0d", i), heads[i], exp_heads[i]);
        chk("drain.stall4", 64'(bus.stall_cnt), 64'd4);

        // streaming across pointer wrap with one entry in flight
        step("wrap", 1'b1, 64'h0, ins_of(64'h0), 1'b0, 1'b0);
        for (int i = 1; i < 11; i++) begin
            chk($sformatf("wrap.head%0d", i - 1), bus.pc_D, 64'((i - 1) * 4));
            chk($sformatf("wrap.instr%0d", i - 1), 64'(bus.instr_D), 64'(ins_of(64'((i - 1) * 4))));
            step("wrap", (i < 10), 64'(i * 4), ins_of(64'(i * 4)), 1'b0, 1'b1);
        end
        chk("wrap.empty", 64'(bus.valid_D), 64'd0);

        // flush with a concurrent offer
        for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 64'(i * 4), ins_of(64'(i * 4)), 1'b0, 1'b0);
        step("flush", 1'b1, 64'h40, ins_of(64'h40), 1'b1, 1'b0);
        chk("flush.valid_D", 64'(bus.valid_D), 64'd0);
        step("post_flush", 1'b1, 64'h80, ins_of(64'h80), 1'b0, 1'b0);
        chk("post_flush.pc_D", bus.pc_D, 64'h80);
        step("drain2", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // empty queue: no bypass
        chk("nobypass.pre", 64'(bus.valid_D), 64'd0);
        step("nobypass", 1'b1, 64'h100, ins_of(64'h100), 1'b0, 1'b1);
        chk("nobypass.pc_D", bus.pc_D, 64'h100);
        step("nobypass_pop", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("nobypass.zero", bus.pc_D, 64'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
                 ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1);
        end

        // asynchronous reset mid-stream with three entries held
        step("rst_prep", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 64'(i * 4 + 'h200), $urandom, 1'b0, 1'b0);
        bus.valid_F = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_stall = '0;
        chk("async_rst.valid_D", 64'(bus.valid_D), 64'd0);
        chk("async_rst.ready_F", 64'(bus.ready_F), 64'd1);
        chk("async_rst.pc_D", bus.pc_D, 64'h0);
        chk("async_rst.stall", 64'(bus.stall_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("async_rst.after");

        // stall counter saturation
        for (int i = 0; i < 4; i++) step("sat_fill", 1'b1, 64'(i), $urandom, 1'b0, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) step("sat", 1'b1, 64'h300, $urandom, 1'b0, 1'b0);
        chk("sat.max", 64'(bus.stall_cnt), 64'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
